// File: rtl/emu_axi_burst_master.sv
// AXI4 INCR burst initiator with a single outstanding transaction.
// One command produces one AR or AW burst. Data moves through pass-through
// valid/ready streams. Completion is a one-cycle pulse carrying the worst
// response seen during the transaction.
module emu_axi_burst_master #(
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         DATA_WIDTH = 64,
    parameter int unsigned         ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    // write-data stream
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    // read-data stream
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    // completion / status
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    busy,
    // AXI write address
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    // AXI write data
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    // AXI write response
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    // AXI read address
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    // AXI read data
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic                    m_axi_rlast
);

    localparam int unsigned           BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned           SIZE_LOG2   = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = ~ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [1:0]            RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            acc_q, acc_d;
    logic                  live_q, live_d;
    logic [1:0]            resp_nxt;
    logic                  unused_ids;

    // AXI response codes are ordered by severity, so "worst" is a numeric max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // cmd_ready stays low through reset and rises only once live_q has been clocked.
    assign cmd_ready  = live_q && (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done_valid = (state_q == ST_DONE);
    assign done_resp  = done_valid ? acc_q : 2'b00;

    assign m_axi_awvalid  = (state_q == ST_AW);
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awid     = AXI_ID;
    assign m_axi_awlen    = len_q;
    assign m_axi_awsize   = 3'(SIZE_LOG2);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = '0;
    assign m_axi_awprot   = '0;
    assign m_axi_awqos    = '0;
    assign m_axi_awregion = '0;

    assign m_axi_arvalid  = (state_q == ST_AR);
    assign m_axi_araddr   = addr_q;
    assign m_axi_arid     = AXI_ID;
    assign m_axi_arlen    = len_q;
    assign m_axi_arsize   = 3'(SIZE_LOG2);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = '0;
    assign m_axi_arprot   = '0;
    assign m_axi_arqos    = '0;
    assign m_axi_arregion = '0;

    assign m_axi_wdata = wr_data;
    assign m_axi_wstrb = wr_strb;
    assign rd_data     = m_axi_rdata;

    // IDs are not needed with only one transaction in flight.
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    // Next-state logic plus the per-state stream gating.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        live_d       = 1'b1;
        resp_nxt     = acc_q;
        wr_ready     = 1'b0;
        rd_valid     = 1'b0;
        rd_last      = 1'b0;
        m_axi_wvalid = 1'b0;
        m_axi_wlast  = 1'b0;
        m_axi_bready = 1'b0;
        m_axi_rready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr & ADDR_MASK;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    acc_d   = 2'b00;
                    state_d = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi_arready) state_d = ST_R;
            end
            ST_R: begin
                rd_valid     = m_axi_rvalid;
                rd_last      = m_axi_rlast;
                m_axi_rready = rd_ready;
                if (m_axi_rvalid && rd_ready) begin
                    cnt_d    = cnt_q + 8'd1;
                    resp_nxt = resp_max(acc_q, m_axi_rresp);
                    // Both length faults collapse to one test: rlast must coincide with beat len.
                    if (m_axi_rlast != (cnt_q == len_q)) begin
                        resp_nxt = (resp_nxt == RESP_DECERR) ? RESP_DECERR : RESP_SLVERR;
                    end
                    acc_d = resp_nxt;
                    if (m_axi_rlast) state_d = ST_DONE;
                end
            end
            ST_AW: begin
                if (m_axi_awready) state_d = ST_W;
            end
            ST_W: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wlast  = (cnt_q == len_q);
                if (wr_valid && m_axi_wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = ST_B;
                end
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    acc_d   = resp_max(acc_q, m_axi_bresp);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= 2'b00;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: doc/emu_axi_burst_master.md
# emu_axi_burst_master

Command-driven AXI4 burst initiator that drives the slave port of the emulated RAM model (`EmuRam`) and of any other AXI4 slave in the emulation library. The block accepts a single read or write command, issues one INCR burst on the matching AR/AW channel and moves data through simple valid/ready streams. It reports completion with a response code. Only one transaction is outstanding at a time. It sits between test or DMA logic and the memory-model interconnect.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 64: AXI data width; a power of two, at least 8.
- `ID_WIDTH`, 4: AXI ID width.
- `AXI_ID`, 0: constant value driven on `awid`/`arid`.
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_write`  in  1: 1 means write burst, 0 means read burst.
- `cmd_addr`  in  ADDR_WIDTH: start address.
- `cmd_len`  in  8: beats minus one (AXI len encoding).
- `wr_valid`, `wr_ready`, `wr_data`, `wr_strb`  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8: write-data stream.
- `rd_valid`, `rd_ready`, `rd_data`, `rd_last`  out/in/out/out  1/1/DATA_WIDTH/1: read-data stream.
- `done_valid`  out  1: one-cycle completion pulse.
- `done_resp`  out  2: final response for the transaction.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `m_axi_aw*`  out: `awvalid`, `awaddr`, `awid`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot`, `awqos`, `awregion`. Widths follow the `EmuRam` slave port.
- `m_axi_awready`  in  1.
- `m_axi_wvalid`, `m_axi_wdata`, `m_axi_wstrb`, `m_axi_wlast`  out; `m_axi_wready`  in.
- `m_axi_bvalid`, `m_axi_bresp`, `m_axi_bid`  in; `m_axi_bready`  out.
- `m_axi_ar*`  out: the same field set as AW; `m_axi_arready`  in.
- `m_axi_rvalid`, `m_axi_rdata`, `m_axi_rresp`, `m_axi_rid`, `m_axi_rlast`  in; `m_axi_rready`  out.

## Operation
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE, on `cmd_valid & cmd_ready`:
  - Register the address with its low log2(DATA_WIDTH/8) bits forced to 0.
  - Register `len`, load the beat counter with 0 and clear the response accumulator to OKAY.
  - Go to AW if `cmd_write`, otherwise to AR.
- AR/AW: `arvalid`/`awvalid` is held high with stable fields until the handshake. Then AR goes to R and AW goes to W.
- Constant fields on both address channels:
  - size = log2(DATA_WIDTH/8) and burst = 2'b01 (INCR).
  - lock, cache, prot, qos and region are all 0.
- No 4 KB splitting is performed. The command source must not cross a 4 KB boundary; behaviour when it does is outside this block.
- R state:
  - Pass-through: `rd_valid = m_axi_rvalid`, `m_axi_rready = rd_ready`, `rd_data = m_axi_rdata`, `rd_last = m_axi_rlast`.
  - Each handshake increments the beat counter and takes the accumulator to max(acc, rresp).
  - On the handshake carrying `rlast`, go to DONE.
  - If `rlast` arrives with counter ≠ len, or the counter reaches len without `rlast`, the accumulator becomes SLVERR (2'b10) unless it is already DECERR. In the second case the block keeps accepting beats until `rlast`.
- W state:
  - Pass-through: `m_axi_wvalid = wr_valid`, `wr_ready = m_axi_wready`; data and strobes pass straight through.
  - `m_axi_wlast` = (counter == len).
  - Handshake with wlast goes to B.
  - W data is never issued before the AW handshake.
- B state: `m_axi_bready = 1`. On `bvalid`, accumulator = max(acc, bresp), then go to DONE.
- DONE: `done_valid = 1` and `done_resp = acc` for exactly one cycle, then go to IDLE.
- `rid`/`bid` are ignored. The single outstanding transaction makes them unambiguous.
- All stream and AXI ready/valid outputs are 0 outside their owning state.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - State is IDLE.
  - `cmd_ready = 0` while `rst_n` is low and 1 from the first cycle after release.
  - All `m_axi_*valid`, `bready`, `rready`, `rd_valid`, `wr_ready`, `done_valid` and `busy` are 0.
  - `done_resp`, address and length registers are 0.
- Command accepted at edge t: `awvalid`/`arvalid` is high from cycle t+1. Address valids are registered outputs.
- R and W data paths have zero latency; they are combinational pass-through.
- Minimum read of N beats with an always-ready slave: command → DONE pulse takes 1 (AR) + N (R) + 1 (DONE) cycles.
- Minimum write of N beats: 1 (AW) + N (W) + ≥1 (B) + 1 (DONE) cycles.
- The next command can be accepted the cycle after DONE; `cmd_ready` is low during DONE.
- Valids never drop before their handshake. Address fields stay stable while valid is high.
- Reset mid-burst aborts immediately with no completion pulse. The attached slave must be reset in the same domain.

## Test plan
- Read, addr 0x100, len 3, slave always ready with rresp OKAY:
  - Required: 4 `rd` beats and `rd_last` on the 4th.
  - `araddr` = 0x100, `arlen` = 3, `arsize` = 3 for 64-bit data.
  - `done_resp` = 0, DONE 6 cycles after acceptance.
- Write, addr 0x207 (unaligned), len 0, one `wr` beat 0xDEADBEEF, strb 0xFF:
  - Required: `awaddr` = 0x200, single beat with `wlast` = 1.
  - bresp OKAY gives `done_resp` = 0.
- Write, len 7, random `wr_valid` gaps and `wready` stalls:
  - Required: 8 beats in order, `wlast` only on beat 8.
  - No `wvalid` before the AW handshake.
- Read, len 3, slave returns SLVERR on beat 2 → `done_resp` = 2.
- Read, len 3, slave asserts `rlast` on beat 2 → 2 beats accepted, `done_resp` = 2, FSM returns to IDLE.
- Assert `rst_n` low during W beat 3 of len 7:
  - Required: all valids 0 in the same cycle, no `done_valid`.
  - `cmd_ready` = 1 one cycle after release.
